seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present on a/b/operation.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 operation  input  4  opcode, per REQ-012.
REQ-009 out_valid  output  1  result on z/flags is valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 z  output  2*WIDTH  result; flags  output  3  {err, dz, zero}.

Function
REQ-012 Opcodes:
- 0 ADD: a+b, carry at z[WIDTH].
- 1 SUB: a-b, borrow at z[WIDTH].
- 2 MUL: a*b, full 2*WIDTH product.
- 3 DIV: quotient in z[WIDTH-1:0], remainder in z[2*WIDTH-1:WIDTH].
- 4 AND, 5 OR, 6 XOR, 7 NOT a, 8 a<<1 (shifted-out bit at z[WIDTH]), 9 a>>1.
- Bits of z not named above are zero.
REQ-013 Opcodes 10..15 SHALL be illegal: z=0, err=1, single-cycle latency.
REQ-014 FSM states: IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-015 Request accepted on rising edge with in_valid&&in_ready; a, b, operation captured at that edge; inputs ignored otherwise.
REQ-016 Single-cycle ops (0,1,4..15): IDLE->DONE; out_valid asserted the cycle after accept.
REQ-017 MUL: iterative shift-add, IDLE->MUL for exactly WIDTH cycles, then DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-018 DIV: iterative restoring division, IDLE->DIV for exactly WIDTH cycles, then DONE; latency WIDTH+1 cycles.
REQ-019 DIV with b=0: quotient all ones, remainder=a, dz=1, same latency as normal DIV.
REQ-020 zero flag = (z==0), computed on the final result.
REQ-021 DONE holds z, flags and out_valid stable until out_valid&&out_ready, then returns to IDLE; next accept no earlier than the following cycle.
REQ-022 z and flags are registered outputs; no combinational path from inputs to z, flags or out_valid.
REQ-023 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Reset
REQ-024 rst asserted at any time, including mid-MUL or mid-DIV, aborts the operation and forces IDLE immediately.
REQ-025 Reset values: in_ready=1, out_valid=0, z=0, flags=0, all iteration counters 0.
REQ-026 First accept possible on the first rising clk edge after rst deasserts.

Configuration
REQ-027 Macro SEQ_ALU_DIV_EN.
- Defined: the divider is present and opcode 3 behaves per REQ-018/REQ-019.
- Undefined: no divider logic is compiled, the DIV state is absent, and opcode 3 is handled as illegal per REQ-013.

Verification (WIDTH=8)
REQ-028 ADD a=200, b=100, op=0 -> out_valid 1 cycle after accept, z=300 (0x12C), flags=000.
REQ-029 MUL a=255, b=255, op=2 -> out_valid 9 cycles after accept, z=0xFE01; in_ready=0 throughout.
REQ-030 DIV a=100, b=7, op=3 with macro defined -> z[7:0]=14, z[15:8]=2. DIV a=5, b=0 -> z[7:0]=0xFF, z[15:8]=5, dz=1. Macro undefined -> z=0, err=1 after 1 cycle.
REQ-031 SUB a=12, b=12, op=1 with out_ready=0 for 5 cycles -> z=0, zero=1; z, flags and out_valid held stable for all 5 cycles; second in_valid ignored until handshake completes.
REQ-032 rst pulsed during cycle 4 of MUL -> out_valid=0, in_ready=1, z=0 immediately; a subsequent op=12 request -> err=1, z=0.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with iterative shift-add multiply and restoring divide.
// Build with SEQ_ALU_DIV_EN defined to include the divider; otherwise opcode 3 is illegal.

module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         operation,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic [2:0]         flags
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef SEQ_ALU_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t               st;
    state_t               st_n;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_n;
    logic [WIDTH:0]       msum;
    logic [2*WIDTH-1:0]   res1;
    logic                 err1;
    logic                 is_long;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem_n;
    logic [WIDTH-1:0]     quo_n;
    logic [WIDTH:0]       shifted;
    logic                 ge;
`endif

    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign last      = (cnt == LAST);

    // Single-cycle results; long ops only flag themselves here.
    always_comb begin
        res1    = '0;
        err1    = 1'b0;
        is_long = 1'b0;
        unique case (operation)
            OP_ADD: res1[WIDTH:0] = {1'b0, a} + {1'b0, b};
            OP_SUB: res1[WIDTH:0] = {1'b0, a} - {1'b0, b};
            OP_MUL: is_long = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: is_long = 1'b1;
`endif
            OP_AND: res1[WIDTH-1:0] = a & b;
            OP_OR:  res1[WIDTH-1:0] = a | b;
            OP_XOR: res1[WIDTH-1:0] = a ^ b;
            OP_NOT: res1[WIDTH-1:0] = ~a;
            OP_SHL: res1[WIDTH:0]   = {a, 1'b0};
            OP_SHR: res1[WIDTH-1:0] = a >> 1;
            default: err1 = 1'b1;
        endcase
    end

    // Multiplier lives in prod's low half and shifts out as partial sums shift in.
    always_comb begin
        msum   = {1'b0, prod[2*WIDTH-1:WIDTH]}
               + (prod[0] ? {1'b0, opb} : '0);
        prod_n = {msum, prod[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    // A zero divisor always "fits", giving all-ones quotient and rem == a.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        ge      = (shifted >= {1'b0, opb});
        rem_n   = ge ? WIDTH'(shifted - {1'b0, opb})
                     : shifted[WIDTH-1:0];
        quo_n   = {quo[WIDTH-2:0], ge};
    end
`endif

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE: begin
                if (in_valid) begin
                    if (operation == OP_MUL)
                        st_n = MUL;
`ifdef SEQ_ALU_DIV_EN
                    else if (operation == OP_DIV)
                        st_n = DIV;
`endif
                    else
                        st_n = DONE;
                end
            end
            MUL: begin
                if (last)
                    st_n = DONE;
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
                if (last)
                    st_n = DONE;
            end
`endif
            DONE: begin
                if (out_ready)
                    st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= IDLE;
        else
            st <= st_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            opb   <= '0;
            prod  <= '0;
            z     <= '0;
            flags <= '0;
`ifdef SEQ_ALU_DIV_EN
            rem   <= '0;
            quo   <= '0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        opb  <= b;
                        prod <= {{WIDTH{1'b0}}, a};
                        cnt  <= '0;
`ifdef SEQ_ALU_DIV_EN
                        rem  <= '0;
                        quo  <= a;
`endif
                        if (!is_long) begin
                            z     <= res1;
                            flags <= {err1, 1'b0, res1 == '0};
                        end
                    end
                end
                MUL: begin
                    prod <= prod_n;
                    cnt  <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        z     <= prod_n;
                        flags <= {2'b00, prod_n == '0};
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        z     <= {rem_n, quo_n};
                        flags <= {1'b0, opb == '0,
                                  {rem_n, quo_n} == '0};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    hold_stable: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(z) && $stable(flags));

    never_both: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));

    cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= LAST);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table plus scoreboard for seq_alu at WIDTH=8.
// Expectations for opcode 3 follow whether SEQ_ALU_DIV_EN is defined.

module tb_seq_alu;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [3:0]     operation;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] z;
    logic [2:0]     flags;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [3:0]     op;
        logic [2*W-1:0] z;
        logic [2:0]     f;
        int             lat;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] z;
        logic [2:0]     f;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [3:0] iop, input logic [2*W-1:0] ez,
                         input logic [2:0] ef);
        int n;
        @(negedge clk);
        a         = ia;
        b         = ib;
        operation = iop;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", in_ready, 1);
        @(posedge clk);
        sbq.push_back('{ez, ef});
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    task automatic wait_result(input int elat, input string nm);
        int   lat;
        exp_t e;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({nm, "_busy_ready"}, in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, elat);
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s_sb actual=empty required=entry", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_z"}, z, e.z);
            chk({nm, "_flags"}, flags, e.f);
        end
    endtask

    task automatic finish_hs(input string nm);
        @(posedge clk);
        #1;
        chk({nm, "_hs_valid"}, out_valid, 0);
        chk({nm, "_hs_ready"}, in_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vt.push_back('{8'd200, 8'd100, 4'd0, 16'h012C, 3'b000, 1});
        vt.push_back('{8'd12,  8'd12,  4'd1, 16'h0000, 3'b001, 1});
        vt.push_back('{8'd3,   8'd5,   4'd1, 16'h01FE, 3'b000, 1});
        vt.push_back('{8'd255, 8'd255, 4'd0, 16'h01FE, 3'b000, 1});
        vt.push_back('{8'd255, 8'd255, 4'd2, 16'hFE01, 3'b000, 9});
        vt.push_back('{8'd0,   8'd77,  4'd2, 16'h0000, 3'b001, 9});
        vt.push_back('{8'd13,  8'd11,  4'd2, 16'h008F, 3'b000, 9});
        vt.push_back('{8'hF0,  8'h3C,  4'd4, 16'h0030, 3'b000, 1});
        vt.push_back('{8'hF0,  8'h0C,  4'd5, 16'h00FC, 3'b000, 1});
        vt.push_back('{8'hFF,  8'h0F,  4'd6, 16'h00F0, 3'b000, 1});
        vt.push_back('{8'h5A,  8'h33,  4'd7, 16'h00A5, 3'b000, 1});
        vt.push_back('{8'h81,  8'h00,  4'd8, 16'h0102, 3'b000, 1});
        vt.push_back('{8'h00,  8'h00,  4'd8, 16'h0000, 3'b001, 1});
        vt.push_back('{8'h81,  8'h00,  4'd9, 16'h0040, 3'b000, 1});
        vt.push_back('{8'h12,  8'h34,  4'd12, 16'h0000, 3'b101, 1});
        vt.push_back('{8'hFF,  8'hFF,  4'd15, 16'h0000, 3'b101, 1});
`ifdef SEQ_ALU_DIV_EN
        vt.push_back('{8'd100, 8'd7,   4'd3, 16'h020E, 3'b000, 9});
        vt.push_back('{8'd5,   8'd0,   4'd3, 16'h05FF, 3'b010, 9});
        vt.push_back('{8'd255, 8'd1,   4'd3, 16'h00FF, 3'b000, 9});
        vt.push_back('{8'd3,   8'd200, 4'd3, 16'h0300, 3'b000, 9});
        vt.push_back('{8'd0,   8'd9,   4'd3, 16'h0000, 3'b001, 9});
`else
        vt.push_back('{8'd100, 8'd7,   4'd3, 16'h0000, 3'b101, 1});
        vt.push_back('{8'd5,   8'd0,   4'd3, 16'h0000, 3'b101, 1});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        operation = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z", z, 0);
        chk("rst_flags", flags, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        foreach (vt[i]) begin
            issue(vt[i].a, vt[i].b, vt[i].op, vt[i].z, vt[i].f);
            wait_result(vt[i].lat, $sformatf("vec%0d", i));
            finish_hs($sformatf("vec%0d", i));
        end

        // Result held under backpressure while a second request waits.
        out_ready = 1'b0;
        issue(8'd12, 8'd12, 4'd1, 16'h0000, 3'b001);
        wait_result(1, "hold");
        in_valid  = 1'b1;
        a         = 8'd1;
        b         = 8'd1;
        operation = 4'd0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_valid", i), out_valid, 1);
            chk($sformatf("hold%0d_z", i), z, 0);
            chk($sformatf("hold%0d_flags", i), flags, 3'b001);
            chk($sformatf("hold%0d_ready", i), in_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_hs_ready", in_ready, 1);
        chk("hold_hs_valid", out_valid, 0);
        chk("hold_hs_z", z, 0);
        @(posedge clk);
        sbq.push_back('{16'h0002, 3'b000});
        #1;
        in_valid = 1'b0;
        wait_result(1, "after_hold");
        finish_hs("after_hold");

        // Reset in the fourth MUL cycle, then an illegal opcode.
        issue(8'd255, 8'd255, 4'd2, 16'hFE01, 3'b000);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid_mul_busy", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_z", z, 0);
        chk("mid_rst_flags", flags, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(8'd7, 8'd9, 4'd12, 16'h0000, 3'b101);
        wait_result(1, "post_rst");
        finish_hs("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
